// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus write sequencer: size codes, FSM states and the size->dmuxu map.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package dbus_pkg;

    // Transfer / memory width encodings (log2 of the byte count)
    localparam logic [1:0] SIZ_B = 2'd0;   // 8-bit byte
    localparam logic [1:0] SIZ_W = 2'd1;   // 16-bit word
    localparam logic [1:0] SIZ_L = 2'd2;   // 32-bit long
    localparam logic [1:0] SIZ_P = 2'd3;   // 64-bit phrase

    // State codes kept as plain constants so legacy netlists and probes
    // that match on raw values stay valid; the enum reuses them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BEAT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BEAT = ST_BEAT,
        DONE = ST_DONE,
        FAIL = ST_FAIL
    } dbus_state_e;

    // Replication selects for the byte mux: smaller transfers are copied
    // up so that every lane the memory might look at carries valid data.
    function automatic logic [2:0] siz_to_dmuxu(input logic [1:0] siz);
        logic [2:0] sel;
        case (siz)
            SIZ_B:   sel = 3'b111;  // byte 0 on all 8 lanes
            SIZ_W:   sel = 3'b110;  // word 0 on all 4 word slots
            SIZ_L:   sel = 3'b100;  // low long mirrored into the high long
            default: sel = 3'b000;  // phrase passes straight through
        endcase
        return sel;
    endfunction

    // Beat width is limited by whichever of transfer and memory is narrower.
    function automatic logic [1:0] min_siz(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dbus_be_gen.sv
// Byte-enable generator: (1 << bw) consecutive lanes starting at lane addr.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   addr - low three address bits of the beat (start lane)
//   bw   - beat width code (SIZ_B..SIZ_P)
//   be   - active-high lane enables, lane n = data bits 8n+7..8n
module dbus_be_gen
    import dbus_pkg::*;
(
    input  logic [2:0] addr,
    input  logic [1:0] bw,
    output logic [7:0] be
);

    logic [7:0] mask;

    // Beats are always naturally aligned to their width, so the shifted
    // mask never spills past lane 7.
    always_comb begin
        mask = 8'h00;
        case (bw)
            SIZ_B:   mask = 8'h01;
            SIZ_W:   mask = 8'h03;
            SIZ_L:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        be = mask << addr;
    end

endmodule

// File: rtl/dbus_wr_seq.sv
// Write sequencer: latches one request, drives dmuxu/byte enables and splits it into memory-width beats.
// Latency: req sampled at cycle 0 -> req_ack + first mem_wr at cycle 1 -> done at cycle 1 + N with mem_rdy high.
// Backpressure: each beat is held until mem_rdy; more than TMO wait cycles on one beat aborts with err.
//
// Ports:
//   sys_clk, resetl             - clock, asynchronous active-low reset
//   req/req_addr/req_siz/mem_wid - request (held until req_ack), sampled only in IDLE
//   req_ack, done, err          - single-cycle status pulses
//   busy                        - high from the req_ack cycle through the done/err cycle
//   dmuxu                       - replication selects, constant for the whole transfer
//   mem_wr/mem_addr/mem_be      - beat strobe, address and byte enables
//   mem_rdy                     - memory takes the current beat at this edge
module dbus_wr_seq
    import dbus_pkg::*;
#(
    parameter int AW  = 24,
    parameter int TMO = 15
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          req,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_siz,
    input  logic [1:0]    mem_wid,
    output logic          req_ack,
    output logic [2:0]    dmuxu,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_be,
    input  logic          mem_rdy,
    output logic          done,
    output logic          err,
    output logic          busy
);

    localparam logic [7:0] TMO_W = 8'(TMO);

    // Registered state
    dbus_state_e   state;
    logic [1:0]    siz_q;        // latched transfer size, drives dmuxu
    logic [1:0]    bw_q;         // latched beat width
    logic [3:0]    beats_left;   // beats remaining after the current one
    logic [7:0]    wait_cnt;     // cycles the current beat has waited
    logic [AW-1:0] addr_q;
    logic [7:0]    be_q;
    logic          ack_q;

    // Next-beat datapath
    logic [1:0]    bw_req;
    logic [AW-1:0] align_mask;
    logic [AW-1:0] addr_nxt;
    logic [1:0]    bw_nxt;
    logic [7:0]    be_nxt;

    // In IDLE the "next" beat is the first beat of the incoming request;
    // in BEAT it is the current beat plus one beat width. The adder wraps
    // naturally at 2^AW.
    always_comb begin
        bw_req     = min_siz(req_siz, mem_wid);
        align_mask = ~((AW'(1) << req_siz) - AW'(1));
        if (state == IDLE) begin
            addr_nxt = req_addr & align_mask;
            bw_nxt   = bw_req;
        end else begin
            addr_nxt = addr_q + (AW'(1) << bw_q);
            bw_nxt   = bw_q;
        end
    end

    dbus_be_gen u_be_gen (
        .addr (addr_nxt[2:0]),
        .bw   (bw_nxt),
        .be   (be_nxt)
    );

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state      <= IDLE;
            siz_q      <= SIZ_B;
            bw_q       <= SIZ_B;
            beats_left <= 4'd0;
            wait_cnt   <= 8'd0;
            addr_q     <= '0;
            be_q       <= 8'h00;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= BEAT;
                        siz_q      <= req_siz;
                        bw_q       <= bw_req;
                        // N = 2^(siz - B) beats; keep N-1 so zero marks the last one
                        beats_left <= (4'd1 << (req_siz - bw_req)) - 4'd1;
                        wait_cnt   <= 8'd0;
                        addr_q     <= addr_nxt;
                        be_q       <= be_nxt;
                        ack_q      <= 1'b1;
                    end
                end
                BEAT: begin
                    // mem_rdy is tested first so it wins over a coincident timeout
                    if (mem_rdy) begin
                        if (beats_left == 4'd0) begin
                            state <= DONE;
                            be_q  <= 8'h00;
                        end else begin
                            beats_left <= beats_left - 4'd1;
                            addr_q     <= addr_nxt;
                            be_q       <= be_nxt;
                            wait_cnt   <= 8'd0;
                        end
                    end else if (wait_cnt == TMO_W) begin
                        state <= FAIL;
                        be_q  <= 8'h00;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin  // DONE / FAIL: one status cycle, then back to IDLE
                    state    <= IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Status decodes come straight off state flops, so an asynchronous
    // reset drops them (and mem_wr) without waiting for a clock edge.
    assign req_ack  = ack_q;
    assign mem_wr   = (state == BEAT);
    assign done     = (state == DONE);
    assign err      = (state == FAIL);
    assign busy     = (state != IDLE);
    assign dmuxu    = busy ? siz_to_dmuxu(siz_q) : 3'b000;
    assign mem_addr = addr_q;
    assign mem_be   = be_q;

endmodule
